// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential Booth multiplier.
package mult_pkg;

  localparam int WIDTH_DEFAULT = 32;
  localparam int ITERATIONS    = WIDTH_DEFAULT / 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    ADD1 = 3'd1,
    ADD2 = 3'd2,
    SUB1 = 3'd3,
    SUB2 = 3'd4
  } booth_op_t;

  // Radix-4 Booth recoding of the window {q[1], q[0], q[-1]}.
  function automatic booth_op_t booth_decode(input logic [2:0] bits);
    booth_op_t op;
    case (bits)
      3'b001, 3'b010: op = ADD1;
      3'b011:         op = ADD2;
      3'b100:         op = SUB2;
      3'b101, 3'b110: op = SUB1;
      default:        op = ZERO;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/booth_mult_seq_if.sv
// Request/response bundle between issue logic and the multiplier.
interface booth_mult_seq_if #(
  parameter int WIDTH = 32
) ();

  logic             start;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic [WIDTH-1:0] result;
  logic             overflow;
  logic             ready;
  logic             busy;

  modport master (
    output start, operand_a, operand_b,
    input  result, overflow, ready, busy
  );

  modport slave (
    input  start, operand_a, operand_b,
    output result, overflow, ready, busy
  );

endinterface

// File: rtl/booth_addsub.sv
// WIDTH-bit add/subtract built from 8-bit lookahead blocks; subtraction
// adds the inverted operand with a carry-in of one. Result is modulo 2^WIDTH.
module booth_addsub #(
  parameter int WIDTH = 34
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum
);

  localparam int NB = (WIDTH + 7) / 8;
  localparam int PW = NB * 8;

  logic [PW-1:0] a_pad;
  logic [PW-1:0] b_pad;
  logic [PW-1:0] sum_pad;
  logic [NB:0]   carry;

  // Padding bits above WIDTH only affect discarded sum bits.
  assign a_pad    = PW'(a);
  assign b_pad    = PW'(sub ? ~b : b);
  assign carry[0] = sub;

  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_blk
      cla8 u_cla8 (
        .a    (a_pad[gi*8 +: 8]),
        .b    (b_pad[gi*8 +: 8]),
        .cin  (carry[gi]),
        .sum  (sum_pad[gi*8 +: 8]),
        .cout (carry[gi+1])
      );
    end
  endgenerate

  assign sum = sum_pad[WIDTH-1:0];

  logic unused_carry;
  assign unused_carry = carry[NB];

  generate
    if (PW > WIDTH) begin : g_pad_unused
      logic unused_pad;
      assign unused_pad = ^sum_pad[PW-1:WIDTH];
    end
  endgenerate

endmodule

// File: rtl/cla8.sv
// 8-bit carry-lookahead adder block; every carry is a flat
// generate/propagate sum of products rather than a ripple chain.
module cla8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [7:0] g;
  logic [7:0] p;
  logic [8:0] c;

  // Carry into bit i+1: OR over j<=i of g[j] & p[j+1..i], plus cin & p[0..i].
  function automatic logic lookahead(input logic [7:0] gv, input logic [7:0] pv,
                                     input logic ci, input int i);
    logic r;
    logic prop;
    r    = 1'b0;
    prop = 1'b1;
    for (int j = i; j >= 0; j--) begin
      r    = r | (gv[j] & prop);
      prop = prop & pv[j];
    end
    return r | (prop & ci);
  endfunction

  assign g    = a & b;
  assign p    = a ^ b;
  assign c[0] = cin;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_bit
      assign c[gi+1]  = lookahead(g, p, cin, gi);
      assign sum[gi]  = p[gi] ^ c[gi];
    end
  endgenerate

  assign cout = c[8];

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-4 Booth signed multiplier: one Booth digit per clock,
// low product word and signed-overflow flag returned on a ready pulse.
module booth_mult_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input logic           clock,
  input logic           reset_n,
  booth_mult_seq_if.slave bus
);

  localparam int ITERS = WIDTH / 2;
  localparam int CW    = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam int AW    = WIDTH + 2;

  state_t            state_reg, state_next;
  logic [AW-1:0]     acc_reg, acc_next;
  logic [WIDTH-1:0]  q_reg, q_next;
  logic              q_m1_reg, q_m1_next;
  logic [AW-1:0]     mcand_reg, mcand_next;
  logic [CW-1:0]     count_reg, count_next;
  logic [WIDTH-1:0]  result_reg, result_next;
  logic              overflow_reg, overflow_next;
  logic              ready_reg, ready_next;
  logic              busy_reg, busy_next;

  booth_op_t         booth_op;
  logic [AW-1:0]     addend;
  logic              sub;
  logic [AW-1:0]     sum;
  logic [AW-1:0]     acc_shift;
  logic [WIDTH-1:0]  q_shift;
  logic              q_m1_shift;
  logic [WIDTH:0]    hi_bits;

  assign booth_op = booth_decode({q_reg[1:0], q_m1_reg});

  // Select the Booth addend (0, +-M, +-2M) for the current digit.
  always_comb begin
    addend = '0;
    sub    = 1'b0;
    case (booth_op)
      ADD1: addend = mcand_reg;
      ADD2: addend = {mcand_reg[AW-2:0], 1'b0};
      SUB1: begin
        addend = mcand_reg;
        sub    = 1'b1;
      end
      SUB2: begin
        addend = {mcand_reg[AW-2:0], 1'b0};
        sub    = 1'b1;
      end
      default: begin
        addend = '0;
        sub    = 1'b0;
      end
    endcase
  end

  booth_addsub #(.WIDTH(AW)) u_addsub (
    .a   (acc_reg),
    .b   (addend),
    .sub (sub),
    .sum (sum)
  );

  // Arithmetic shift of {sum, q, q_m1} right by two positions.
  assign acc_shift  = {{2{sum[AW-1]}}, sum[AW-1:2]};
  assign q_shift    = {sum[1:0], q_reg[WIDTH-1:2]};
  assign q_m1_shift = q_reg[1];

  // Product fits in WIDTH signed bits only if the upper word equals the low word's sign.
  assign hi_bits = {acc_shift[WIDTH-1:0], q_shift[WIDTH-1]};

  // Next-state, datapath update and registered-output values.
  always_comb begin
    state_next    = state_reg;
    acc_next      = acc_reg;
    q_next        = q_reg;
    q_m1_next     = q_m1_reg;
    mcand_next    = mcand_reg;
    count_next    = count_reg;
    result_next   = result_reg;
    overflow_next = overflow_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          state_next = RUN;
          acc_next   = '0;
          q_next     = bus.operand_b;
          q_m1_next  = 1'b0;
          mcand_next = {{2{bus.operand_a[WIDTH-1]}}, bus.operand_a};
          count_next = '0;
        end
      end
      RUN: begin
        acc_next   = acc_shift;
        q_next     = q_shift;
        q_m1_next  = q_m1_shift;
        count_next = count_reg + 1'b1;
        if (count_reg == CW'(ITERS - 1)) begin
          state_next    = DONE;
          result_next   = q_shift;
          overflow_next = ~((&hi_bits) | ~(|hi_bits));
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    ready_next = (state_next == DONE);
    busy_next  = (state_next != IDLE);
  end

  // State and datapath registers; reset abandons any in-flight operation.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      acc_reg      <= '0;
      q_reg        <= '0;
      q_m1_reg     <= 1'b0;
      mcand_reg    <= '0;
      count_reg    <= '0;
      result_reg   <= '0;
      overflow_reg <= 1'b0;
      ready_reg    <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      acc_reg      <= acc_next;
      q_reg        <= q_next;
      q_m1_reg     <= q_m1_next;
      mcand_reg    <= mcand_next;
      count_reg    <= count_next;
      result_reg   <= result_next;
      overflow_reg <= overflow_next;
      ready_reg    <= ready_next;
      busy_reg     <= busy_next;
    end
  end

  assign bus.result   = result_reg;
  assign bus.overflow = overflow_reg;
  assign bus.ready    = ready_reg;
  assign bus.busy     = busy_reg;

endmodule
